// File: rtl/dot_map.sv
// dot_map -- per-cell dot storage for a tile map.
//
// The map is divided into NX x NY square cells of CELL pixels. Each cell
// holds one bit (1 = dot present). The Pacman position (set_x/set_y) eats
// the dot in its cell on a clock edge. A pixel query (query_x/query_y)
// reads the current cell bit combinationally for the renderer.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous active-high reset; restores every dot
//   set_x      in   9   Pacman centre x, map-relative pixels
//   set_y      in   9   Pacman centre y, map-relative pixels
//   query_x    in  11   pixel x being drawn (>= 1024 is a negative wrap)
//   query_y    in  11   pixel y being drawn (>= 1024 is a negative wrap)
//   dot        out  1   query cell still holds a dot (0 when out of range)
//   new_eat    out  1   one-cycle pulse: a dot was eaten on the last edge
//   eaten_cnt  out 10   dots eaten since reset, saturates at NX*NY
//   all_clear  out  1   eaten_cnt == NX*NY
//
// The eat pulse is named new_eat because "new" is a reserved word in
// SystemVerilog and cannot be used as a port name.
module dot_map #(
  parameter int MAP_W = 348,
  parameter int MAP_H = 408,
  parameter int CELL  = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  set_x,
  input  logic [8:0]  set_y,
  input  logic [10:0] query_x,
  input  logic [10:0] query_y,
  output logic        dot,
  output logic        new_eat,
  output logic [9:0]  eaten_cnt,
  output logic        all_clear
);

  localparam int NX    = MAP_W / CELL;
  localparam int NY    = MAP_H / CELL;
  localparam int NCELL = NX * NY;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  // Partial cells past the last full column/row do not exist, so the
  // usable area is the whole-cell extent, not the raw map size.
  localparam int XLIM  = NX * CELL;
  localparam int YLIM  = NY * CELL;
  localparam logic [9:0] NCELL_V = 10'(NCELL);

  logic [NCELL-1:0] dots;

  logic          set_ok, q_ok, eat;
  logic [IW-1:0] set_idx, q_idx;

  // Linear cell index = row*NX + col; only meaningful when in range.
  function automatic logic [IW-1:0] cell_idx(input int px, input int py);
    int idx;
    idx = (py / CELL) * NX + (px / CELL);
    return idx[IW-1:0];
  endfunction

  always_comb begin
    set_ok  = (int'(set_x) < XLIM) && (int'(set_y) < YLIM);
    q_ok    = (int'(query_x) < XLIM) && (int'(query_y) < YLIM);
    set_idx = set_ok ? cell_idx(int'(set_x), int'(set_y)) : '0;
    q_idx   = q_ok ? cell_idx(int'(query_x), int'(query_y)) : '0;
    eat     = set_ok && dots[set_idx];
    // Reads storage before the edge, so a same-cycle eat still shows the dot.
    dot       = q_ok && dots[q_idx];
    all_clear = (eaten_cnt == NCELL_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dots      <= '1;
      eaten_cnt <= '0;
      new_eat   <= 1'b0;
    end else begin
      new_eat <= eat;
      if (eat) begin
        dots[set_idx] <= 1'b0;
        if (eaten_cnt != NCELL_V)
          eaten_cnt <= eaten_cnt + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_dot_map.sv
// Scoreboard bench for dot_map: each clock edge pushes the expected
// {new_eat, eaten_cnt, all_clear} from a row/column reference model; the
// entry is popped and compared just after the edge. Dot queries are
// compared against the same reference grid between edges.
module tb_dot_map;
  localparam int NX = 29;
  localparam int NY = 34;
  localparam int NC = NX * NY;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  set_x, set_y;
  logic [10:0] query_x, query_y;
  logic        dot, new_eat, all_clear;
  logic [9:0]  eaten_cnt;

  dot_map dut (
    .clk(clk), .reset(reset), .set_x(set_x), .set_y(set_y),
    .query_x(query_x), .query_y(query_y), .dot(dot), .new_eat(new_eat),
    .eaten_cnt(eaten_cnt), .all_clear(all_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nw;
    int cnt;
    int clr;
  } exp_t;

  exp_t exp_q[$];
  bit   mdl[NY][NX];
  int   m_cnt;
  int   errors = 0;
  int   checks = 0;
  int   pulses;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance the model for the inputs now applied, push the expectation,
  // clock the DUT, then pop and compare.
  task automatic tick(input string tag);
    exp_t e;
    int   x, y;
    e.nw = 0;
    x = int'(set_x);
    y = int'(set_y);
    if (reset) begin
      for (int r = 0; r < NY; r++)
        for (int c = 0; c < NX; c++) mdl[r][c] = 1'b1;
      m_cnt = 0;
    end else if (x < 348 && y < 408 && mdl[y / 12][x / 12]) begin
      mdl[y / 12][x / 12] = 1'b0;
      if (m_cnt < NC) m_cnt++;
      e.nw = 1;
    end
    e.cnt = m_cnt;
    e.clr = (m_cnt == NC) ? 1 : 0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".new"}, int'(new_eat), e.nw);
    chk({tag, ".cnt"}, int'(eaten_cnt), e.cnt);
    chk({tag, ".clr"}, int'(all_clear), e.clr);
    if (new_eat) pulses++;
  endtask

  task automatic setp(input int x, input int y);
    set_x = 9'(x);
    set_y = 9'(y);
  endtask

  // Combinational read; at most three per inter-edge gap.
  task automatic qchk(input string tag, input int x, input int y);
    int ex;
    query_x = 11'(x);
    query_y = 11'(y);
    #1;
    ex = (x < 348 && y < 408) ? int'(mdl[y / 12][x / 12]) : 0;
    chk(tag, int'(dot), ex);
  endtask

  initial begin
    m_cnt = 0;
    pulses = 0;
    reset = 1'b1;
    setp(500, 500);
    query_x = '0;
    query_y = '0;
    tick("rst0");
    tick("rst1");
    reset = 1'b0;
    tick("idle");
    qchk("q0_0", 0, 0);
    qchk("q347_407", 347, 407);
    qchk("q200_100", 200, 100);

    // Single eat, then hold on the eaten cell.
    setp(18, 18);
    tick("eat18");
    chk("eat18.pulse", int'(new_eat), 1);
    for (int i = 0; i < 10; i++) tick("hold18");
    setp(500, 500);
    tick("idle");
    qchk("q12_12", 12, 12);
    qchk("q23_23", 23, 23);
    qchk("q24_12", 24, 12);

    // Same-cell set and query: dot visible before the edge only.
    setp(30, 30);
    qchk("same.pre", 30, 30);
    chk("same.pre1", int'(dot), 1);
    tick("same");
    setp(500, 500);
    qchk("same.post", 30, 30);

    // Out-of-range sets and queries.
    setp(348, 0);   tick("oor348");
    setp(0, 408);   tick("oor408");
    setp(500, 500); tick("oor500");
    qchk("qneg", 2047, 0);
    qchk("q348", 348, 0);
    qchk("qyneg", 0, 2047);
    tick("idle");
    qchk("q407y", 0, 407);

    // A few more eats, then reset together with a set on an uneaten cell.
    setp(100, 200); tick("eatA");
    setp(340, 400); tick("eatB");
    setp(100, 100);
    reset = 1'b1;
    tick("rstset");
    reset = 1'b0;
    setp(500, 500);
    qchk("rst.q18", 18, 18);
    qchk("rst.q100", 100, 100);
    qchk("rst.q340", 340, 400);

    // Sweep every cell centre.
    pulses = 0;
    for (int r = 0; r < NY; r++)
      for (int c = 0; c < NX; c++) begin
        setp(c * 12 + 6, r * 12 + 6);
        tick("sweep");
      end
    chk("sweep.pulses", pulses, NC);
    chk("sweep.clr", int'(all_clear), 1);
    setp(6, 6);     tick("after0");
    setp(347, 407); tick("after1");
    setp(500, 500);
    qchk("clr.q0", 0, 0);
    qchk("clr.q347", 347, 407);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dot_map.md
DOT_MAP -- requirements
Module: dot_map

Interface
REQ-001 Parameter MAP_W, default 348, map width in pixels.
REQ-002 Parameter MAP_H, default 408, map height in pixels.
REQ-003 Parameter CELL, default 12, cell edge in pixels; grid is NX = MAP_W/CELL = 29 columns by NY = MAP_H/CELL = 34 rows (986 cells).
REQ-004 One clock; reset is synchronous and active-high: ports clk and reset.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 set_x  input  9  Pacman centre x, map-relative pixels.
REQ-008 set_y  input  9  Pacman centre y, map-relative pixels.
REQ-009 query_x  input  11  pixel x being drawn, map-relative; values of 1024 and above are negative wrap-arounds, treated as out of range.
REQ-010 query_y  input  11  pixel y being drawn, map-relative; same out-of-range rule as query_x.
REQ-011 dot  output  1  1 = the cell containing the query pixel still holds a dot.
REQ-012 new  output  1  one-cycle pulse: a dot was eaten on this edge.
REQ-013 eaten_cnt  output  10  number of dots eaten since reset.
REQ-014 all_clear  output  1  1 when eaten_cnt equals NX*NY.

Function
REQ-015 Storage: one bit per cell; 1 = dot present; cell index = row*NX + col.
REQ-016 Cell mapping: col = floor(px/CELL), row = floor(py/CELL); integer division, no rounding.
REQ-017 Query range: query is in range only if query_x < MAP_W and query_y < MAP_H.
REQ-018 dot output: combinational from the current storage for the query cell, no clock latency; dot = 0 when the query is out of range.
REQ-019 Set range: set is valid only if set_x < MAP_W and set_y < MAP_H; an invalid set has no effect.
REQ-020 Eat condition: on every rising edge without reset, if the set is valid and the set cell bit is 1, clear that bit.
REQ-021 Eat pulse: when the eat condition holds, new = 1 for exactly the following cycle; otherwise new = 0.
REQ-022 Eat count: when the eat condition holds, eaten_cnt increments by 1.
REQ-023 Eaten cell: a cell that is already clear produces no pulse and no count change, even if the set position is held for many cycles.
REQ-024 Same cell: query and set on the same cell in the same cycle gives dot = 1 in that cycle and dot = 0 after the edge.
REQ-025 eaten_cnt saturation: eaten_cnt never exceeds NX*NY.
REQ-026 all_clear is combinational from eaten_cnt.
REQ-027 At most one cell changes per clock.
REQ-028 Cells beyond the last full column or row (pixel 348+ or 408+) do not exist.

Reset
REQ-029 When reset = 1 at a rising edge, all 986 cell bits are set to 1.
REQ-030 When reset = 1 at a rising edge, eaten_cnt = 0, new = 0 and all_clear = 0.
REQ-031 Reset has priority over the eat condition in the same cycle.
REQ-032 Reset asserted mid-game restores every dot on the next edge.

Verification
REQ-033 Reset, then query (0,0), (347,407) and (200,100) -> dot = 1 at each; new = 0; eaten_cnt = 0.
REQ-034 set (18,18) for one edge -> new pulses 1 for one cycle; eaten_cnt = 1; query (12,12) and (23,23) -> dot = 0; query (24,12) -> dot = 1.
REQ-035 Hold set (18,18) for 10 edges after it is eaten -> new stays 0; eaten_cnt stays 1.
REQ-036 set (348,0), then (0,408), then (500,500) -> no change and new = 0; query_x = 2047 (i.e. -1) or query (348,0) -> dot = 0.
REQ-037 Sweep set over the centres of all 986 cells -> 986 pulses; eaten_cnt = 986; all_clear = 1; further sets -> no pulse.
REQ-038 After several eats, assert reset together with a set on an uneaten cell -> all dots = 1, eaten_cnt = 0, new = 0 on the next cycle.
